// File: rtl/wave_ch_pkg.sv
// -----------------------------------------------------------------------------
// wave_ch_pkg
// Shared definitions for the wave-table sound channel:
//   - register addresses and register bit positions
//   - volume code enumeration
//   - reset constants
// Optional feature macro used by the design files: WAVE_CH_DUAL_BANK_EN
// -----------------------------------------------------------------------------
package wave_ch_pkg;

  // Register addresses
  localparam logic [2:0] REG_CTRL    = 3'd0;  // bit7 DAC enable (+ bank bits)
  localparam logic [2:0] REG_LEN     = 3'd1;  // length value L
  localparam logic [2:0] REG_VOL     = 3'd2;  // bits[7:5] volume code
  localparam logic [2:0] REG_FREQ_LO = 3'd3;  // frequency bits [7:0]
  localparam logic [2:0] REG_FREQ_HI = 3'd4;  // freq high, length enable, trigger

  // Register bit positions
  localparam int CTRL_DAC_EN_BIT = 7;
  localparam int CTRL_BANK_BIT   = 6;
  localparam int CTRL_DBL_BIT    = 5;
  localparam int HI_LEN_EN_BIT   = 6;
  localparam int HI_TRIG_BIT     = 7;

  // Volume codes; codes 5..7 are not listed and mute the output
  typedef enum logic [2:0] {
    VOL_MUTE = 3'd0,
    VOL_100  = 3'd1,
    VOL_50   = 3'd2,
    VOL_25   = 3'd3,
    VOL_75   = 3'd4
  } vol_code_e;

  // Reset constants
  localparam logic       RST_BIT = 1'b0;
  localparam logic [2:0] VOL_RST = VOL_MUTE;

endpackage

// File: rtl/wave_ch_if.sv
// -----------------------------------------------------------------------------
// wave_ch_if
// CPU-side bus of the wave channel: register write strobe and wave RAM
// read/write port.
//   master : register decode / CPU side (drives strobes, address, data)
//   slave  : wave channel (returns ram_rdata)
// Signals:
//   reg_wr, reg_addr[2:0], reg_wdata[7:0]   register write
//   ram_wr, ram_rd, ram_addr[PW:0]          wave RAM access strobes/address
//   ram_wdata, ram_rdata [SAMPLE_W-1:0]     wave RAM data
// ram_addr MSB is meaningful only when WAVE_CH_DUAL_BANK_EN is defined.
// -----------------------------------------------------------------------------
interface wave_ch_if #(
  parameter int SAMPLE_W = 4,
  parameter int PW       = 5
);
  logic                reg_wr;
  logic [2:0]          reg_addr;
  logic [7:0]          reg_wdata;
  logic                ram_wr;
  logic                ram_rd;
  logic [PW:0]         ram_addr;
  logic [SAMPLE_W-1:0] ram_wdata;
  logic [SAMPLE_W-1:0] ram_rdata;

  modport master (
    output reg_wr, reg_addr, reg_wdata,
    output ram_wr, ram_rd, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  reg_wr, reg_addr, reg_wdata,
    input  ram_wr, ram_rd, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/wave_ch_ram.sv
// -----------------------------------------------------------------------------
// wave_ch_ram
// Sample storage for the wave channel with one asynchronous playback read
// port and one CPU read/write port (registered read data). The bank
// multiplexing between playback and CPU lives here.
// Macro: WAVE_CH_DUAL_BANK_EN -- 2*DEPTH words, play bank select and
// 2*DEPTH play mode; otherwise a single DEPTH-word bank.
// Ports:
//   clk, i_rst            clock, synchronous active-high reset (read data only)
//   i_active              channel running (locks the CPU port)
//   i_dbl_mode            pointer spans both banks (dual-bank build only)
//   i_play_bank           bank being played (dual-bank build only)
//   i_play_pos[PW:0]      play pointer; MSB used only in 2*DEPTH mode
//   o_play_data           sample at the play pointer (combinational)
//   i_cpu_wr/i_cpu_rd     CPU strobes
//   i_cpu_addr[PW:0]      CPU address; MSB used only in 2*DEPTH mode
//   i_cpu_wdata           CPU write sample
//   o_cpu_rdata           CPU read sample, valid the cycle after i_cpu_rd
// -----------------------------------------------------------------------------
module wave_ch_ram #(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int PW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_active,
  input  logic                i_dbl_mode,
  input  logic                i_play_bank,
  input  logic [PW:0]         i_play_pos,
  output logic [SAMPLE_W-1:0] o_play_data,
  input  logic                i_cpu_wr,
  input  logic                i_cpu_rd,
  input  logic [PW:0]         i_cpu_addr,
  input  logic [SAMPLE_W-1:0] i_cpu_wdata,
  output logic [SAMPLE_W-1:0] o_cpu_rdata
);

`ifdef WAVE_CH_DUAL_BANK_EN
  localparam int AW = PW + 1;
`else
  localparam int AW = PW;
`endif
  localparam int WORDS = 1 << AW;

  logic [SAMPLE_W-1:0] r_mem [WORDS];
  logic [SAMPLE_W-1:0] r_cpu_rdata;
  logic [AW-1:0]       w_play_idx;
  logic [AW-1:0]       w_cpu_idx;
  logic [AW-1:0]       w_rd_idx;
  logic                w_cpu_locked;

`ifdef WAVE_CH_DUAL_BANK_EN
  // Banked mode: CPU works on the bank that is not being played, so it may
  // rewrite the table while the channel runs. 2*DEPTH mode plays both banks
  // and falls back to the single-bank locking behaviour.
  assign w_play_idx   = i_dbl_mode ? i_play_pos : {i_play_bank, i_play_pos[PW-1:0]};
  assign w_cpu_idx    = i_dbl_mode ? i_cpu_addr : {~i_play_bank, i_cpu_addr[PW-1:0]};
  assign w_cpu_locked = i_active && i_dbl_mode;
`else
  logic w_unused_bank_bits;
  assign w_unused_bank_bits = ^{i_dbl_mode, i_play_bank, i_play_pos[PW], i_cpu_addr[PW]};
  assign w_play_idx   = i_play_pos[PW-1:0];
  assign w_cpu_idx    = i_cpu_addr[PW-1:0];
  assign w_cpu_locked = i_active;
`endif

  // While locked the CPU sees the sample currently being played.
  assign w_rd_idx    = w_cpu_locked ? w_play_idx : w_cpu_idx;
  assign o_play_data = r_mem[w_play_idx];
  assign o_cpu_rdata = r_cpu_rdata;

  // NOTE: the sample array has no reset; its contents must survive apu_reset
  // and a reset port on a RAM prevents mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (i_cpu_wr && !w_cpu_locked) begin
      r_mem[w_cpu_idx] <= i_cpu_wdata;
    end
  end

  // Read-before-write: a same-cycle write and read returns the old sample.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cpu_rdata <= '0;
    end else if (i_cpu_rd) begin
      r_cpu_rdata <= r_mem[w_rd_idx];
    end
  end

endmodule

// File: rtl/wave_channel_gen.sv
// -----------------------------------------------------------------------------
// wave_channel_gen
// Parametrised wave-table sound channel. Plays a CPU-loaded table of
// SAMPLE_W-bit samples at a programmable rate, with a length timer, output
// attenuation (mute/100/50/25/75 %) and DAC gating.
// Macro: WAVE_CH_DUAL_BANK_EN -- two banks, play-bank select (reg0 bit6) and
// 2*DEPTH mode (reg0 bit5).
// Ports:
//   cery_2mhz      clock, rising edge
//   apu_reset      synchronous active-high reset
//   tick_256hz     one-cycle length-clock enable
//   cpu            wave_ch_if.slave: register writes and wave RAM access
//   active         channel running
//   dac_out        attenuated sample to the mixer
//   sample_strobe  one-cycle pulse when dac_out takes a new sample
// -----------------------------------------------------------------------------
module wave_channel_gen
  import wave_ch_pkg::*;
#(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8
) (
  input  logic                cery_2mhz,
  input  logic                apu_reset,
  input  logic                tick_256hz,
  wave_ch_if.slave            cpu,
  output logic                active,
  output logic [SAMPLE_W-1:0] dac_out,
  output logic                sample_strobe
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  // Register file
  logic              r_dac_en;
  logic              r_len_en;
  logic [2:0]        r_vol;
  logic [FREQ_W-1:0] r_freq;

  // Channel state
  logic [FREQ_W-1:0]   r_freq_cnt;
  logic [PW:0]         r_pos;
  logic [LEN_W:0]      r_len_cnt;
  logic                r_active;
  logic                r_fetch;
  logic                r_strobe;
  logic [SAMPLE_W-1:0] r_buf;

  // Decode
  logic                w_wr_ctrl, w_wr_len, w_wr_vol, w_wr_lo, w_wr_hi;
  logic                w_trigger;
  logic                w_dac_en_nxt;
  logic [FREQ_W-1:0]   w_freq_nxt;
  logic [LEN_W:0]      w_len_load;
  logic [PW:0]         w_pos_inc;
  logic                w_dbl_mode;
  logic                w_play_bank;
  logic [SAMPLE_W-1:0] w_play_data;
  logic [SAMPLE_W+1:0] w_s3;
  logic [SAMPLE_W-1:0] w_vol_out;

  assign w_wr_ctrl = cpu.reg_wr && (cpu.reg_addr == REG_CTRL);
  assign w_wr_len  = cpu.reg_wr && (cpu.reg_addr == REG_LEN);
  assign w_wr_vol  = cpu.reg_wr && (cpu.reg_addr == REG_VOL);
  assign w_wr_lo   = cpu.reg_wr && (cpu.reg_addr == REG_FREQ_LO);
  assign w_wr_hi   = cpu.reg_wr && (cpu.reg_addr == REG_FREQ_HI);
  assign w_trigger = w_wr_hi && cpu.reg_wdata[HI_TRIG_BIT];

  // Look-ahead values so a write acts on the very next edge.
  assign w_dac_en_nxt = w_wr_ctrl ? cpu.reg_wdata[CTRL_DAC_EN_BIT] : r_dac_en;
  assign w_len_load   = LEN_FULL - {1'b0, LEN_W'(cpu.reg_wdata)};

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_freq_nxt = r_freq;
    if (w_wr_lo) w_freq_nxt[7:0]        = cpu.reg_wdata;
    if (w_wr_hi) w_freq_nxt[FREQ_W-1:8] = cpu.reg_wdata[FREQ_W-9:0];
  end

`ifdef WAVE_CH_DUAL_BANK_EN
  logic r_bank_sel;
  logic r_dbl_mode;
  assign w_dbl_mode  = r_dbl_mode;
  assign w_play_bank = r_bank_sel;
`else
  assign w_dbl_mode  = 1'b0;
  assign w_play_bank = 1'b0;
`endif

  // In 2*DEPTH mode the pointer uses its MSB; otherwise it wraps at DEPTH-1.
  assign w_pos_inc = w_dbl_mode ? r_pos + (PW+1)'(1)
                                : {1'b0, r_pos[PW-1:0] + PW'(1)};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge cery_2mhz) begin
    if (apu_reset) begin
      r_dac_en <= RST_BIT;
      r_len_en <= RST_BIT;
      r_vol    <= VOL_RST;
      r_freq   <= '0;
`ifdef WAVE_CH_DUAL_BANK_EN
      r_bank_sel <= RST_BIT;
      r_dbl_mode <= RST_BIT;
`endif
    end else begin
      r_freq <= w_freq_nxt;
      if (w_wr_ctrl) begin
        r_dac_en <= cpu.reg_wdata[CTRL_DAC_EN_BIT];
`ifdef WAVE_CH_DUAL_BANK_EN
        r_bank_sel <= cpu.reg_wdata[CTRL_BANK_BIT];
        r_dbl_mode <= cpu.reg_wdata[CTRL_DBL_BIT];
`endif
      end
      if (w_wr_vol) r_vol    <= cpu.reg_wdata[7:5];
      if (w_wr_hi)  r_len_en <= cpu.reg_wdata[HI_LEN_EN_BIT];
    end
  end

  always_ff @(posedge cery_2mhz) begin
    if (apu_reset) begin
      r_freq_cnt <= '0;
      r_pos      <= '0;
      r_len_cnt  <= '0;
      r_active   <= RST_BIT;
      r_fetch    <= RST_BIT;
      r_strobe   <= RST_BIT;
      r_buf      <= '0;
    end else begin
      // The buffer loads one cycle after the pointer advance, so it reads
      // the sample at the already-updated position.
      r_fetch  <= 1'b0;
      r_strobe <= r_fetch;
      if (r_fetch) r_buf <= w_play_data;

      if (w_trigger) begin
        // Trigger overrides a same-cycle length tick; the buffer keeps its
        // old sample and the first fetch will be position 1.
        r_freq_cnt <= w_freq_nxt;
        r_pos      <= '0;
        if (r_len_cnt == '0) r_len_cnt <= LEN_FULL;
        r_active   <= w_dac_en_nxt;
      end else begin
        if (w_wr_len) begin
          r_len_cnt <= w_len_load;
        end else if (tick_256hz && r_len_en && r_active && (r_len_cnt != '0)) begin
          r_len_cnt <= r_len_cnt - (LEN_W+1)'(1);
          if (r_len_cnt == (LEN_W+1)'(1)) r_active <= 1'b0;
        end

        if (r_active) begin
          if (&r_freq_cnt) begin
            r_freq_cnt <= r_freq;  // new frequency takes effect here
            r_pos      <= w_pos_inc;
            r_fetch    <= 1'b1;
          end else begin
            r_freq_cnt <= r_freq_cnt + FREQ_W'(1);
          end
        end

        if (!w_dac_en_nxt) r_active <= 1'b0;
      end
    end
  end

  // Attenuation; 75 % is (s + 2s) >> 2 with the sum widened to avoid overflow.
  always_comb begin
    w_s3      = {2'b00, r_buf} + {1'b0, r_buf, 1'b0};
    w_vol_out = '0;
    case (r_vol)
      VOL_MUTE: w_vol_out = '0;
      VOL_100:  w_vol_out = r_buf;
      VOL_50:   w_vol_out = r_buf >> 1;
      VOL_25:   w_vol_out = r_buf >> 2;
      VOL_75:   w_vol_out = w_s3[SAMPLE_W+1:2];
      default:  w_vol_out = '0;
    endcase
  end

  assign active        = r_active;
  assign dac_out       = r_active ? w_vol_out : '0;
  assign sample_strobe = r_strobe;

  wave_ch_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .PW       (PW)
  ) u_ram (
    .clk         (cery_2mhz),
    .i_rst       (apu_reset),
    .i_active    (r_active),
    .i_dbl_mode  (w_dbl_mode),
    .i_play_bank (w_play_bank),
    .i_play_pos  (r_pos),
    .o_play_data (w_play_data),
    .i_cpu_wr    (cpu.ram_wr),
    .i_cpu_rd    (cpu.ram_rd),
    .i_cpu_addr  (cpu.ram_addr),
    .i_cpu_wdata (cpu.ram_wdata),
    .o_cpu_rdata (cpu.ram_rdata)
  );

endmodule
